// File: rtl/agc_mem_if.sv
// Request/response bus between the AGC datapath (master) and its memory responder (slave).
interface agc_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic        super_bit;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_reg_hit;
    logic        rsp_fault;
    logic        rsp_parity_err;
    logic [2:0]  ebank;
    logic [4:0]  fbank;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, super_bit,
        input  req_ready, rsp_valid, rsp_rdata, rsp_reg_hit, rsp_fault,
               rsp_parity_err, ebank, fbank
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, super_bit,
        output req_ready, rsp_valid, rsp_rdata, rsp_reg_hit, rsp_fault,
               rsp_parity_err, ebank, fbank
    );
endinterface

// File: rtl/agc_mem_responder.sv
// AGC memory responder: EB/FB/BB bank translation over erasable and fixed arrays, odd parity.
// Optional feature macro: AGC_MEM_PARITY_CHECK_EN (flags even-parity words on array reads).
module agc_mem_responder #(
    parameter int    MEM_LAT   = 2,
    parameter int    FIX_BANKS = 36,
    parameter string FIX_INIT  = "fixed.hex",
    parameter string ERA_INIT  = ""
) (
    input logic      clk,
    input logic      rst_n,
    agc_mem_if.slave bus
);
    localparam int ERA_WORDS = 2048;
    localparam int FIX_WORDS = FIX_BANKS * 1024;
    localparam int FIX_AW    = $clog2(FIX_WORDS);
    localparam int CNT_W     = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [6:0] FIX_BANKS_V = 7'(FIX_BANKS);

    if (MEM_LAT < 1 || FIX_BANKS < 1 || FIX_BANKS > 64) begin : g_bad_params
        $error("agc_mem_responder: MEM_LAT must be >= 1 and FIX_BANKS in 1..64");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    function automatic logic [15:0] with_parity(input logic [14:0] d);
        return {d, ~^d};
    endfunction

    logic [15:0] era_mem [ERA_WORDS];
    logic [15:0] fix_mem [FIX_WORDS];

    state_t             state;
    logic [CNT_W-1:0]   lat_cnt;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [15:0]        rsp_rdata_q;
    logic               rsp_reg_hit_q;
    logic               rsp_fault_q;
    logic [2:0]         ebank_q;
    logic [4:0]         fbank_q;

    logic               cap_we;
    logic [11:0]        cap_addr;
    logic [14:0]        cap_d;
    logic               cap_super;

    // Request fields come straight off the bus in the accept cycle, from the capture regs afterwards.
    logic               cur_we;
    logic [11:0]        cur_addr;
    logic [14:0]        cur_d;
    logic               cur_super;
    logic               in_idle;

    assign in_idle   = (state == S_IDLE);
    assign cur_we    = in_idle ? bus.req_we            : cap_we;
    assign cur_addr  = in_idle ? bus.req_addr          : cap_addr;
    assign cur_d     = in_idle ? bus.req_wdata[15:1]   : cap_d;
    assign cur_super = in_idle ? bus.super_bit         : cap_super;

    logic unused_wdata_parity;
    assign unused_wdata_parity = bus.req_wdata[0];

    logic               is_low;
    logic               is_era;
    logic [2:0]         era_bank;
    logic [10:0]        era_phys;
    logic [5:0]         fb_eff;
    logic [5:0]         fix_bank;
    logic [15:0]        fix_phys;
    logic               fix_ok;
    logic [15:0]        era_rd;
    logic [15:0]        fix_rd;
    logic [15:0]        wr_word;

    assign is_low   = (cur_addr[11:3] == '0);
    assign is_era   = (cur_addr[11:10] == 2'b00) && !is_low;
    assign era_bank = (cur_addr[9:8] == 2'b11) ? ebank_q : {1'b0, cur_addr[9:8]};
    assign era_phys = {era_bank, cur_addr[7:0]};
    assign fb_eff   = (cur_super && (fbank_q >= 5'o30)) ? ({1'b0, fbank_q} + 6'o10)
                                                        : {1'b0, fbank_q};
    assign fix_bank = cur_addr[11] ? {4'b0000, cur_addr[11:10]} : fb_eff;
    assign fix_phys = {fix_bank, cur_addr[9:0]};
    assign fix_ok   = ({1'b0, fix_bank} < FIX_BANKS_V);
    assign era_rd   = era_mem[era_phys];
    assign fix_rd   = fix_mem[fix_phys[FIX_AW-1:0]];
    assign wr_word  = with_parity(cur_d);

    logic [15:0]        nxt_rdata;
    logic               nxt_reg_hit;
    logic               nxt_fault;
    logic [2:0]         nxt_ebank;
    logic [4:0]         nxt_fbank;
    logic               era_wr_sel;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        nxt_rdata   = '0;
        nxt_reg_hit = 1'b0;
        nxt_fault   = 1'b0;
        nxt_ebank   = ebank_q;
        nxt_fbank   = fbank_q;
        era_wr_sel  = 1'b0;
        if (is_low) begin
            case (cur_addr[2:0])
                3'o3: begin
                    if (cur_we) nxt_ebank = cur_d[10:8];
                    nxt_rdata = with_parity({4'b0000, nxt_ebank, 8'h00});
                end
                3'o4: begin
                    if (cur_we) nxt_fbank = cur_d[14:10];
                    nxt_rdata = with_parity({nxt_fbank, 10'h000});
                end
                3'o6: begin
                    if (cur_we) begin
                        nxt_fbank = cur_d[14:10];
                        nxt_ebank = cur_d[2:0];
                    end
                    nxt_rdata = with_parity({nxt_fbank, 7'h00, nxt_ebank});
                end
                3'o7:    nxt_rdata = 16'h0001;
                default: nxt_reg_hit = 1'b1;
            endcase
        end else if (is_era) begin
            if (cur_we) begin
                era_wr_sel = 1'b1;
                nxt_rdata  = wr_word;
            end else begin
                nxt_rdata  = era_rd;
            end
        end else if (!fix_ok) begin
            nxt_fault = 1'b1;
        end else begin
            // Fixed memory is read-only: a write reports a fault and returns the current word.
            nxt_rdata = fix_rd;
            nxt_fault = cur_we;
        end
    end

    logic accept;
    logic go_resp;
    logic era_we;

    assign accept  = in_idle && bus.req_valid;
    assign go_resp = (accept && (MEM_LAT == 1 || is_low)) ||
                     ((state == S_BUSY) && (lat_cnt == '0));
    assign era_we  = rst_n && go_resp && era_wr_sel;

    // NOTE: storage arrays carry no reset; only the control state below is cleared by rst_n.
    always_ff @(posedge clk) begin
        if (era_we) era_mem[era_phys] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            lat_cnt       <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_reg_hit_q <= 1'b0;
            rsp_fault_q   <= 1'b0;
            ebank_q       <= '0;
            fbank_q       <= '0;
            cap_we        <= 1'b0;
            cap_addr      <= '0;
            cap_d         <= '0;
            cap_super     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_reg_hit_q <= 1'b0;
            rsp_fault_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cap_we      <= bus.req_we;
                        cap_addr    <= bus.req_addr;
                        cap_d       <= bus.req_wdata[15:1];
                        cap_super   <= bus.super_bit;
                        req_ready_q <= 1'b0;
                        lat_cnt     <= CNT_W'(MEM_LAT - 2);
                        state       <= go_resp ? S_RESP : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (lat_cnt == '0) state <= S_RESP;
                    else               lat_cnt <= lat_cnt - CNT_W'(1);
                end
                S_RESP: begin
                    state       <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
            if (go_resp) begin
                rsp_valid_q   <= 1'b1;
                rsp_rdata_q   <= nxt_rdata;
                rsp_reg_hit_q <= nxt_reg_hit;
                rsp_fault_q   <= nxt_fault;
                ebank_q       <= nxt_ebank;
                fbank_q       <= nxt_fbank;
            end
        end
    end

`ifdef AGC_MEM_PARITY_CHECK_EN
    logic arr_read;
    logic rsp_par_q;

    assign arr_read = !is_low && !cur_we && (is_era || fix_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsp_par_q <= 1'b0;
        else        rsp_par_q <= go_resp && arr_read && !(^nxt_rdata);
    end

    assign bus.rsp_parity_err = rsp_par_q;
`else
    assign bus.rsp_parity_err = 1'b0;
`endif

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_reg_hit = rsp_reg_hit_q;
    assign bus.rsp_fault   = rsp_fault_q;
    assign bus.ebank       = ebank_q;
    assign bus.fbank       = fbank_q;
endmodule

// File: tb/tb_agc_mem_responder.sv
// Directed bench for agc_mem_responder (MEM_LAT=2, 36 fixed banks, arrays preloaded by the bench).
`timescale 1ns/1ps
module tb_agc_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    agc_mem_if bus ();

    agc_mem_responder #(
        .MEM_LAT   (2),
        .FIX_BANKS (36),
        .FIX_INIT  (""),
        .ERA_INIT  ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef AGC_MEM_PARITY_CHECK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One bus transaction: drive at negedge, accept on the next posedge, then scramble the
    // request lines and wait (bounded) for the response strobe.
    task automatic do_req(input string tag, input logic we, input logic [11:0] addr,
                          input logic [15:0] wdata, input logic sup, input int exp_lat,
                          input logic [15:0] exp_rdata, input logic exp_hit,
                          input logic exp_fault, input logic exp_perr);
        int          lat;
        logic [15:0] rdata;
        logic        hit, fault, perr;
        lat   = 0;
        rdata = '0;
        hit   = 1'b0;
        fault = 1'b0;
        perr  = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.super_bit = sup;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wdata;
        bus.super_bit = ~sup;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat   = n;
                rdata = bus.rsp_rdata;
                hit   = bus.rsp_reg_hit;
                fault = bus.rsp_fault;
                perr  = bus.rsp_parity_err;
            end
        end
        check({tag, ".lat"},   lat,   exp_lat);
        check({tag, ".rdata"}, rdata, exp_rdata);
        check({tag, ".hit"},   hit,   exp_hit);
        check({tag, ".fault"}, fault, exp_fault);
        check({tag, ".perr"},  perr,  exp_perr);
        @(negedge clk);
        check({tag, ".strobe"}, bus.rsp_valid, 1'b0);
        check({tag, ".ready"},  bus.req_ready, 1'b1);
    endtask

    initial begin
        logic seen;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.super_bit = 1'b0;
        #1;
        dut.fix_mem[32768] = 16'h1113;
        dut.fix_mem[24576] = 16'h2226;
        dut.fix_mem[2048]  = 16'h4321;
        dut.fix_mem[3072]  = 16'h0800;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst.ready", bus.req_ready,   1'b1);
        check("rst.valid", bus.rsp_valid,   1'b0);
        check("rst.rdata", bus.rsp_rdata,   16'h0000);
        check("rst.hit",   bus.rsp_reg_hit, 1'b0);
        check("rst.fault", bus.rsp_fault,   1'b0);
        check("rst.perr",  bus.rsp_parity_err, 1'b0);
        check("rst.ebank", bus.ebank,       3'd0);
        check("rst.fbank", bus.fbank,       5'd0);

        // Bank registers and the zero/CPU-register addresses answer in one cycle.
        do_req("rd_eb",   1'b0, 12'o3, 16'h0000, 1'b0, 1, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("eb_is0", bus.ebank, 3'd0);
        do_req("wr_eb",   1'b1, 12'o3, 16'h0A00, 1'b0, 1, 16'h0A01, 1'b0, 1'b0, 1'b0);
        check("eb_is5", bus.ebank, 3'd5);

        // Erasable: switched bank via EB, fixed banks 0..2, parity regeneration.
        do_req("wr_era",  1'b1, 12'o1400, 16'h1234, 1'b0, 2, 16'h1234, 1'b0, 1'b0, 1'b0);
        check("era_phys1280", dut.era_mem[1280], 16'h1234);
        do_req("rd_era",  1'b0, 12'o1400, 16'hFFFF, 1'b0, 2, 16'h1234, 1'b0, 1'b0, 1'b0);
        do_req("wr_par",  1'b1, 12'o1401, 16'h1235, 1'b0, 2, 16'h1234, 1'b0, 1'b0, 1'b0);
        do_req("rd_par",  1'b0, 12'o1401, 16'h0000, 1'b0, 2, 16'h1234, 1'b0, 1'b0, 1'b0);
        do_req("wr_eb2",  1'b1, 12'o1000, 16'h0002, 1'b0, 2, 16'h0002, 1'b0, 1'b0, 1'b0);
        check("era_phys512", dut.era_mem[512], 16'h0002);

        // Fixed: superbank remap of FB=030, then an out-of-range bank.
        do_req("wr_fb",   1'b1, 12'o4, 16'hC000, 1'b0, 1, 16'hC001, 1'b0, 1'b0, 1'b0);
        check("fb_is030", bus.fbank, 5'o30);
        do_req("fix_sb1", 1'b0, 12'o2000, 16'h0000, 1'b1, 2, 16'h1113, 1'b0, 1'b0, 1'b0);
        do_req("fix_sb0", 1'b0, 12'o2000, 16'h0000, 1'b0, 2, 16'h2226, 1'b0, 1'b0, 1'b0);
        do_req("wr_fb37", 1'b1, 12'o4, 16'hF800, 1'b0, 1, 16'hF800, 1'b0, 1'b0, 1'b0);
        do_req("fix_oor", 1'b0, 12'o2000, 16'h0000, 1'b1, 2, 16'h0000, 1'b0, 1'b1, 1'b0);
        do_req("rd_bb",   1'b0, 12'o6, 16'h0000, 1'b0, 1, 16'hF80A, 1'b0, 1'b0, 1'b0);
        do_req("wr_bb",   1'b1, 12'o6, 16'hC00A, 1'b0, 1, 16'hC00B, 1'b0, 1'b0, 1'b0);
        check("bb_fb", bus.fbank, 5'o30);
        check("bb_eb", bus.ebank, 3'd5);

        // Write to fixed memory faults and leaves the word intact.
        do_req("fix_wr",  1'b1, 12'o4000, 16'h7FFF, 1'b0, 2, 16'h4321, 1'b0, 1'b1, 1'b0);
        do_req("fix_rr",  1'b0, 12'o4000, 16'h0000, 1'b0, 2, 16'h4321, 1'b0, 1'b0, 1'b0);
        do_req("fix_b3",  1'b0, 12'o6000, 16'h0000, 1'b0, 2, 16'h0800, 1'b0, 1'b0, 1'b0);

        // Even-parity stored word.
        dut.fix_mem[2048] = 16'h0000;
        do_req("fix_perr", 1'b0, 12'o4000, 16'h0000, 1'b0, 2, 16'h0000, 1'b0, 1'b0, PAR_EN);

        // CPU-held registers and the zero word.
        do_req("rd_z",    1'b0, 12'o5, 16'h0000, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_req("wr_a",    1'b1, 12'o0, 16'hFFFF, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_req("wr_zero", 1'b1, 12'o7, 16'hFFFF, 1'b0, 1, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_req("rd_zero", 1'b0, 12'o7, 16'h0000, 1'b0, 1, 16'h0001, 1'b0, 1'b0, 1'b0);

        // Reset during BUSY aborts the write and suppresses the response.
        do_req("wr_pre",  1'b1, 12'o1500, 16'h5556, 1'b0, 2, 16'h5557, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 12'o1500;
        bus.req_wdata = 16'h0F0E;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("abort.no_rsp", seen, 1'b0);
        check("abort.word",   dut.era_mem[1344], 16'h5557);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort.ready", bus.req_ready, 1'b1);
        check("abort.ebank", bus.ebank, 3'd0);
        do_req("wr_eb5",   1'b1, 12'o3, 16'h0A00, 1'b0, 1, 16'h0A01, 1'b0, 1'b0, 1'b0);
        do_req("rd_after", 1'b0, 12'o1500, 16'h0000, 1'b0, 2, 16'h5557, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
